// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage with a two-entry buffer: CUR holds the demand-fetched
// word, NXT holds a sequential prefetch of CUR+1, filled over a req/ack memory port.
module ifetch_prefetch #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        flush,
  output logic [15:0] instruction,
  output logic        instr_valid,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        fetch_err
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH, ERR} state_t;

  state_t          state, state_nx;
  logic            cur_v, cur_v_nx, nxt_v, nxt_v_nx;
  logic [AW-1:0]   cur_a, cur_a_nx, nxt_a, nxt_a_nx;
  logic [DW-1:0]   cur_d, cur_d_nx, nxt_d, nxt_d_nx;
  logic [AW-1:0]   req_addr, req_addr_nx;
  logic [AW-1:0]   mem_addr_nx;
  logic            mem_req_nx, fetch_err_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            drop, drop_nx;
  logic            hit_c, hit_n, ack_cycle;

  assign hit_c     = cur_v && (cur_a == pc);
  assign hit_n     = nxt_v && (nxt_a == pc);
  assign ack_cycle = mem_ack && ((state == DEMAND) || (state == PREFETCH));

  assign instr_valid = (hit_c || hit_n) && (state != ERR);
  assign instruction = !instr_valid ? '0 : (hit_c ? cur_d : nxt_d);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_v     <= 1'b0;
      cur_a     <= '0;
      cur_d     <= '0;
      nxt_v     <= 1'b0;
      nxt_a     <= '0;
      nxt_d     <= '0;
      req_addr  <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      fetch_err <= 1'b0;
      cnt       <= '0;
      drop      <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_v     <= cur_v_nx;
      cur_a     <= cur_a_nx;
      cur_d     <= cur_d_nx;
      nxt_v     <= nxt_v_nx;
      nxt_a     <= nxt_a_nx;
      nxt_d     <= nxt_d_nx;
      req_addr  <= req_addr_nx;
      mem_req   <= mem_req_nx;
      mem_addr  <= mem_addr_nx;
      fetch_err <= fetch_err_nx;
      cnt       <= cnt_nx;
      drop      <= drop_nx;
    end
  end

  // Next-state, buffer update and request issue
  always_comb begin
    state_nx     = state;
    cur_v_nx     = cur_v;
    cur_a_nx     = cur_a;
    cur_d_nx     = cur_d;
    nxt_v_nx     = nxt_v;
    nxt_a_nx     = nxt_a;
    nxt_d_nx     = nxt_d;
    req_addr_nx  = req_addr;
    mem_req_nx   = mem_req;
    mem_addr_nx  = mem_addr;
    fetch_err_nx = fetch_err;
    cnt_nx       = cnt;
    drop_nx      = drop;

    // Promote NXT to CUR once the core moves onto it; held off while a fill lands
    if ((state != ERR) && hit_n && !hit_c && !flush && !ack_cycle) begin
      cur_v_nx = 1'b1;
      cur_a_nx = nxt_a;
      cur_d_nx = nxt_d;
      nxt_v_nx = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!flush) begin
          if (!hit_c && !hit_n) begin
            mem_req_nx  = 1'b1;
            mem_addr_nx = pc;
            req_addr_nx = pc;
            cnt_nx      = '0;
            drop_nx     = 1'b0;
            state_nx    = DEMAND;
          end else if (hit_c && !(nxt_v && (nxt_a == cur_a + 16'd1))) begin
            mem_req_nx  = 1'b1;
            mem_addr_nx = cur_a + 16'd1;
            cnt_nx      = '0;
            drop_nx     = 1'b0;
            state_nx    = PREFETCH;
          end
        end
      end
      DEMAND, PREFETCH: begin
        if (mem_ack) begin
          mem_req_nx = 1'b0;
          drop_nx    = 1'b0;
          state_nx   = IDLE;
          if (!drop && !flush) begin
            if (state == DEMAND) begin
              cur_v_nx = 1'b1;
              cur_a_nx = req_addr;
              cur_d_nx = mem_rdata;
            end else begin
              nxt_v_nx = 1'b1;
              nxt_a_nx = mem_addr;
              nxt_d_nx = mem_rdata;
            end
          end
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          mem_req_nx   = 1'b0;
          fetch_err_nx = 1'b1;
          state_nx     = ERR;
        end else begin
          cnt_nx = cnt + 8'd1;
          if (flush) drop_nx = 1'b1;
        end
      end
      default: begin
        state_nx = ERR;
      end
    endcase

    if (flush && (state != ERR)) begin
      cur_v_nx = 1'b0;
      nxt_v_nx = 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed cycle-by-cycle vectors for ifetch_prefetch plus hand sequences for
// asynchronous reset behaviour.
module tb_ifetch_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'h0;
  logic        flush = 1'b0;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  ifetch_prefetch #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush),
    .instruction(instruction), .instr_valid(instr_valid),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic        flush;
    logic        ack;
    logic [15:0] rdata;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic [15:0] p, input logic f, input logic a,
                   input logic [15:0] d, input logic e_req, input logic [15:0] e_addr,
                   input logic e_vld, input logic [15:0] e_instr, input logic e_err);
    vec_t t;
    t.rst = r; t.pc = p; t.flush = f; t.ack = a; t.rdata = d;
    t.req = e_req; t.addr = e_addr; t.vld = e_vld; t.instr = e_instr; t.err = e_err;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic e_req, input logic [15:0] e_addr,
                           input logic e_vld, input logic [15:0] e_instr, input logic e_err);
    check("mem_req", idx, 16'(mem_req), 16'(e_req));
    check("mem_addr", idx, mem_addr, e_addr);
    check("instr_valid", idx, 16'(instr_valid), 16'(e_vld));
    check("instruction", idx, instruction, e_instr);
    check("fetch_err", idx, 16'(fetch_err), 16'(e_err));
  endtask

  initial begin
    // Memory contents used throughout: word(a) = 16'h3123 + a
    //  rst pc       fl ack rdata    | req addr     vld instr    err
    v(1, 16'h0000, 0, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 0); // 0 reset
    v(0, 16'h0000, 0, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 0); // 1 cold miss
    v(0, 16'h0000, 0, 1, 16'h3123,   1, 16'h0000, 0, 16'h0000, 0); // 2 zero-wait ack
    v(0, 16'h0000, 0, 0, 16'h0000,   0, 16'h0000, 1, 16'h3123, 0); // 3 hit
    v(0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0001, 1, 16'h3123, 0); // 4 prefetch 1
    v(0, 16'h0001, 0, 1, 16'h3124,   1, 16'h0001, 0, 16'h0000, 0); // 5
    v(0, 16'h0001, 0, 0, 16'h0000,   0, 16'h0001, 1, 16'h3124, 0); // 6 NXT hit
    v(0, 16'h0001, 0, 0, 16'h0000,   0, 16'h0001, 1, 16'h3124, 0); // 7 promoted
    v(0, 16'h0001, 0, 1, 16'h3125,   1, 16'h0002, 1, 16'h3124, 0); // 8 prefetch 2
    v(0, 16'h0002, 0, 0, 16'h0000,   0, 16'h0002, 1, 16'h3125, 0); // 9
    v(0, 16'h0002, 0, 0, 16'h0000,   0, 16'h0002, 1, 16'h3125, 0); // 10
    v(0, 16'h0003, 0, 1, 16'h3126,   1, 16'h0003, 0, 16'h0000, 0); // 11
    v(0, 16'h0003, 0, 0, 16'h0000,   0, 16'h0003, 1, 16'h3126, 0); // 12
    v(0, 16'h0003, 0, 0, 16'h0000,   0, 16'h0003, 1, 16'h3126, 0); // 13
    v(0, 16'h000C, 0, 0, 16'h0000,   1, 16'h0004, 0, 16'h0000, 0); // 14 branch
    v(0, 16'h000C, 0, 1, 16'h3127,   1, 16'h0004, 0, 16'h0000, 0); // 15 prefetch lands
    v(0, 16'h000C, 0, 0, 16'h0000,   0, 16'h0004, 0, 16'h0000, 0); // 16
    v(0, 16'h000C, 0, 1, 16'h312F,   1, 16'h000C, 0, 16'h0000, 0); // 17 demand 12
    v(0, 16'h000C, 0, 0, 16'h0000,   0, 16'h000C, 1, 16'h312F, 0); // 18
    v(0, 16'h000C, 0, 1, 16'h3130,   1, 16'h000D, 1, 16'h312F, 0); // 19
    v(0, 16'hFFFF, 0, 0, 16'h0000,   0, 16'h000D, 0, 16'h0000, 0); // 20
    v(0, 16'hFFFF, 0, 1, 16'h3122,   1, 16'hFFFF, 0, 16'h0000, 0); // 21
    v(0, 16'hFFFF, 0, 0, 16'h0000,   0, 16'hFFFF, 1, 16'h3122, 0); // 22
    v(0, 16'hFFFF, 0, 1, 16'h3123,   1, 16'h0000, 1, 16'h3122, 0); // 23 wrap
    v(0, 16'h0000, 0, 0, 16'h0000,   0, 16'h0000, 1, 16'h3123, 0); // 24
    v(0, 16'h0004, 0, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 0); // 25
    v(0, 16'h0004, 1, 1, 16'h3127,   1, 16'h0004, 0, 16'h0000, 0); // 26 flush+ack
    v(0, 16'h0004, 0, 0, 16'h0000,   0, 16'h0004, 0, 16'h0000, 0); // 27
    v(0, 16'h0004, 0, 0, 16'h0000,   1, 16'h0004, 0, 16'h0000, 0); // 28 reissue
    v(0, 16'h0004, 0, 1, 16'h3127,   1, 16'h0004, 0, 16'h0000, 0); // 29
    v(0, 16'h0004, 0, 0, 16'h0000,   0, 16'h0004, 1, 16'h3127, 0); // 30
    v(0, 16'h0004, 0, 0, 16'h0000,   1, 16'h0005, 1, 16'h3127, 0); // 31 wait 1
    v(0, 16'h0004, 0, 0, 16'h0000,   1, 16'h0005, 1, 16'h3127, 0); // 32 wait 2
    v(0, 16'h0004, 0, 0, 16'h0000,   1, 16'h0005, 1, 16'h3127, 0); // 33 wait 3
    v(0, 16'h0004, 0, 0, 16'h0000,   1, 16'h0005, 1, 16'h3127, 0); // 34 wait 4
    v(0, 16'h0004, 0, 0, 16'h0000,   0, 16'h0005, 0, 16'h0000, 1); // 35 ERR
    v(0, 16'h0004, 1, 1, 16'h3127,   0, 16'h0005, 0, 16'h0000, 1); // 36
    v(0, 16'h0004, 0, 0, 16'h0000,   0, 16'h0005, 0, 16'h0000, 1); // 37

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; pc = vecs[i].pc; flush = vecs[i].flush;
      mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
      #1;
      check_all(i, vecs[i].req, vecs[i].addr, vecs[i].vld, vecs[i].instr, vecs[i].err);
    end

    // Asynchronous reset out of ERR, between clock edges
    #2; rst = 1'b1; flush = 1'b0; mem_ack = 1'b0;
    #1;
    check("async_rst_err", 100, 16'(fetch_err), 16'h0);
    check("async_rst_req", 100, 16'(mem_req), 16'h0);

    // Reset during an outstanding demand; a late ack must be ignored
    @(negedge clk); rst = 1'b0; pc = 16'h0008;
    #1; check_all(101, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    @(negedge clk); #1;
    check_all(102, 1'b1, 16'h0008, 1'b0, 16'h0000, 1'b0);
    #1; rst = 1'b1; #1;
    check("rst_drops_req", 103, 16'(mem_req), 16'h0);
    @(negedge clk); rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1234;
    #1; check_all(104, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    @(negedge clk); mem_ack = 1'b0;
    #1; check_all(105, 1'b1, 16'h0008, 1'b0, 16'h0000, 1'b0);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'h312B;
    #1; check_all(106, 1'b1, 16'h0008, 1'b0, 16'h0000, 1'b0);
    @(negedge clk); mem_ack = 1'b0;
    #1; check_all(107, 1'b0, 16'h0008, 1'b1, 16'h312B, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
